morse_transmitter: RTL
======================

MORSE_TRANSMITTER -- requirements
Module: morse_transmitter

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 12500000, meaning clock cycles per Morse time unit (minimum 2).
REQ-002 The block SHALL have parameter TONE_HALF_CYCLES, default 25000, meaning clock cycles per tone half-period (used only under REQ-027).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle transmit request.
REQ-006 The block SHALL have port final_seq_of_in, input, 40 bits: eight 5-bit element patterns, with slot k at [39-5k:35-5k]; bit i is element i (0 = dot, 1 = dash).
REQ-007 The block SHALL have port final_num_of_in, input, 24 bits: eight 3-bit element counts, with slot k at [23-3k:21-3k].
REQ-008 The block SHALL have port char_count, input, 4 bits: number of slots to send, starting from slot 0.
REQ-009 The block SHALL have port key_out, output, 1 bit: keying output, 1 = mark.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a transmission is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port char_pos, output, 3 bits: slot currently being sent.
REQ-013 The block SHALL have port tone_out, output, 1 bit: audio square wave.

Function
REQ-014 The FSM SHALL have states IDLE, MARK, GAP and DONE.
REQ-015 In IDLE, the block SHALL accept start, snapshot final_seq_of_in, final_num_of_in and char_count, and later input changes SHALL be ignored until the next IDLE.
REQ-016 start SHALL be ignored while busy = 1.
REQ-017 char_count values above 8 SHALL be treated as 8.
REQ-018 If char_count = 0, done SHALL pulse on the cycle after start, with no mark sent.
REQ-019 Timing SHALL be: dot mark 1 unit; dash mark 3 units; gap between elements 1 unit; gap between characters 3 units; slot with count 0 = 7-unit space (word gap) with no mark; counts above 5 treated as 5.
REQ-020 key_out SHALL rise the cycle after start is accepted; busy SHALL rise the same cycle and SHALL stay high through the done cycle.
REQ-021 No trailing gap SHALL follow the last element; done SHALL pulse on the cycle key_out falls after the final mark, or after the final word-gap space ends; the FSM SHALL then return to IDLE.
REQ-022 char_pos SHALL track the active slot and SHALL hold the last slot until the next start.
REQ-023 Internal counters SHALL be sized for UNIT_CYCLES*7 without wrap.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: FSM to IDLE; key_out, busy, done and tone_out to 0; char_pos to 0; all counters cleared.
REQ-025 Reset asserted mid-transmission SHALL abort it with no done pulse.
REQ-026 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-027 With macro MORSE_TX_TONE_EN defined, tone_out SHALL toggle every TONE_HALF_CYCLES cycles while key_out = 1, and SHALL be 0 otherwise, with the phase counter reset at each mark start.
REQ-028 Without MORSE_TX_TONE_EN, tone_out SHALL be tied to 0 and no tone counter SHALL exist.

Structure
REQ-029 Shared package morse_pkg SHALL hold: DOT_UNITS = 1, DASH_UNITS = 3, ELEM_GAP_UNITS = 1, CHAR_GAP_UNITS = 3, WORD_GAP_UNITS = 7, MAX_ELEMS = 5, NUM_SLOTS = 8, and the FSM state typedef.
REQ-030 Sub-module morse_unit_timer SHALL be loaded with a unit count, SHALL count UNIT_CYCLES per unit, and SHALL assert expire for one cycle.

Verification (UNIT_CYCLES = 4)
REQ-031 Slot 0 = "E" (pattern 00000, count 1), char_count = 1, start -> key_out high for exactly 4 cycles starting the cycle after start; done on the fall cycle; busy high for 5 cycles.
REQ-032 Slot 0 = "A" (pattern 00010, count 2) -> key_out pattern: high 4, low 4, high 12; done when key_out falls.
REQ-033 Slots "E", count 0, "T" (00001, count 1), char_count = 3 -> high 4, low 12, low 28, low 12, high 12, then done.
REQ-034 start pulsed mid-transmission, with inputs changed mid-transmission -> output waveform unchanged; no restart.
REQ-035 rst_n low during a dash -> key_out and busy go to 0 asynchronously; no done; a new start after release transmits normally.
REQ-036 With MORSE_TX_TONE_EN and TONE_HALF_CYCLES = 2, "E" -> tone_out toggles every 2 cycles during the 4-cycle mark and is 0 otherwise; char_count = 0 -> done the cycle after start, key_out stays 0.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse timing constants, FSM state type and element-count clamp
// used by the Morse transmitter and its unit timer.
package morse_pkg;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int MAX_ELEMS      = 5;
    localparam int NUM_SLOTS      = 8;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP,
        DONE
    } state_t;

    // A GAP is either between elements, between characters, or a whole word space
    typedef enum logic [1:0] {
        GAP_ELEM,
        GAP_CHAR,
        GAP_WORD
    } gap_kind_t;

    function automatic logic [2:0] clamp_elems(input logic [2:0] n);
        return (n > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : n;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring a whole number of Morse units; expire
// pulses for one cycle on the last cycle of the loaded interval.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] units,
    output logic       expire
);

    localparam int CNT_W = $clog2(UNIT_CYCLES * WORD_GAP_UNITS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    // The load pulse arrives one cycle after the segment began, so the
    // reload value is shortened by two to end the segment on time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= CNT_W'(int'(units) * UNIT_CYCLES - 2);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/morse_transmitter.sv
// Keys out up to eight Morse characters from a snapshot of the pattern inputs.
// Optional audio tone output is enabled with macro MORSE_TX_TONE_EN.
module morse_transmitter
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = 12500000,
    parameter int TONE_HALF_CYCLES = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [39:0] final_seq_of_in,
    input  logic [23:0] final_num_of_in,
    input  logic [3:0]  char_count,
    output logic        key_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  char_pos,
    output logic        tone_out
);

    state_t      state_q;
    gap_kind_t   gap_kind_q;
    logic [39:0] seq_q;
    logic [23:0] num_q;
    logic [3:0]  total_q;
    logic [2:0]  slot_q;
    logic [2:0]  elem_q;
    logic        tmr_load;
    logic [2:0]  tmr_units;
    logic        tmr_expire;

    logic [4:0]  cur_seq;
    logic [4:0]  nxt_seq;
    logic [2:0]  cur_len;
    logic [2:0]  nxt_len;
    logic [2:0]  nxt_slot;
    logic [2:0]  in_len0;
    logic        last_slot;
    logic        last_elem;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .units  (tmr_units),
        .expire (tmr_expire)
    );

    // Slot 0 sits in the top bits, so slot k is found by shifting the packed vectors down.
    always_comb begin
        nxt_slot  = slot_q + 3'd1;
        cur_seq   = 5'(seq_q >> (MAX_ELEMS * (NUM_SLOTS - 1 - int'(slot_q))));
        nxt_seq   = 5'(seq_q >> (MAX_ELEMS * (NUM_SLOTS - 1 - int'(nxt_slot))));
        cur_len   = clamp_elems(3'(num_q >> (3 * (NUM_SLOTS - 1 - int'(slot_q)))));
        nxt_len   = clamp_elems(3'(num_q >> (3 * (NUM_SLOTS - 1 - int'(nxt_slot)))));
        in_len0   = clamp_elems(final_num_of_in[23:21]);
        last_slot = ({1'b0, slot_q} + 4'd1) >= total_q;
        last_elem = (elem_q + 3'd1) >= cur_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_kind_q <= GAP_ELEM;
            seq_q      <= '0;
            num_q      <= '0;
            total_q    <= '0;
            slot_q     <= '0;
            elem_q     <= '0;
            tmr_load   <= 1'b0;
            tmr_units  <= '0;
            key_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tmr_load <= 1'b0;
            done     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        seq_q   <= final_seq_of_in;
                        num_q   <= final_num_of_in;
                        total_q <= (char_count > 4'(NUM_SLOTS)) ? 4'(NUM_SLOTS) : char_count;
                        slot_q  <= '0;
                        elem_q  <= '0;
                        busy    <= 1'b1;
                        if (char_count == 4'd0) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else if (in_len0 == 3'd0) begin
                            state_q    <= GAP;
                            gap_kind_q <= GAP_WORD;
                            tmr_load   <= 1'b1;
                            tmr_units  <= 3'(WORD_GAP_UNITS);
                        end else begin
                            state_q   <= MARK;
                            key_out   <= 1'b1;
                            tmr_load  <= 1'b1;
                            tmr_units <= final_seq_of_in[35] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
                        end
                    end
                end
                MARK: begin
                    if (tmr_expire) begin
                        key_out <= 1'b0;
                        if (!last_elem) begin
                            state_q    <= GAP;
                            gap_kind_q <= GAP_ELEM;
                            elem_q     <= elem_q + 3'd1;
                            tmr_load   <= 1'b1;
                            tmr_units  <= 3'(ELEM_GAP_UNITS);
                        end else if (!last_slot) begin
                            state_q    <= GAP;
                            gap_kind_q <= GAP_CHAR;
                            tmr_load   <= 1'b1;
                            tmr_units  <= 3'(CHAR_GAP_UNITS);
                        end else begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tmr_expire) begin
                        case (gap_kind_q)
                            GAP_ELEM: begin
                                state_q   <= MARK;
                                key_out   <= 1'b1;
                                tmr_load  <= 1'b1;
                                tmr_units <= cur_seq[elem_q] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
                            end
                            GAP_CHAR: begin
                                slot_q   <= nxt_slot;
                                elem_q   <= '0;
                                tmr_load <= 1'b1;
                                if (nxt_len == 3'd0) begin
                                    gap_kind_q <= GAP_WORD;
                                    tmr_units  <= 3'(WORD_GAP_UNITS);
                                end else begin
                                    state_q   <= MARK;
                                    key_out   <= 1'b1;
                                    tmr_units <= nxt_seq[0] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
                                end
                            end
                            default: begin
                                if (!last_slot) begin
                                    gap_kind_q <= GAP_CHAR;
                                    tmr_load   <= 1'b1;
                                    tmr_units  <= 3'(CHAR_GAP_UNITS);
                                end else begin
                                    state_q <= DONE;
                                    done    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign char_pos = slot_q;

`ifdef MORSE_TX_TONE_EN
    localparam int TONE_W = $clog2(TONE_HALF_CYCLES + 1);

    logic [TONE_W-1:0] tone_cnt_q;
    logic              tone_q;

    // Counter is held clear whenever unkeyed, so every mark starts at phase zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (!key_out) begin
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (tone_cnt_q == TONE_W'(TONE_HALF_CYCLES - 1)) begin
            tone_cnt_q <= '0;
            tone_q     <= ~tone_q;
        end else begin
            tone_cnt_q <= tone_cnt_q + TONE_W'(1);
        end
    end

    assign tone_out = tone_q & key_out;
`else
    assign tone_out = 1'b0 & (TONE_HALF_CYCLES > 0);
`endif

endmodule
